aud_rec_writer: RTL

AUD_REC_WRITER -- requirements
Module: aud_rec_writer

---
 rtl/aud_pkg.sv | 23 ++
 rtl/i2s_rx_shift.sv | 57 +++++
 rtl/aud_rec_writer.sv | 111 +++++++++++
 3 files changed

// File: rtl/aud_pkg.sv
// rtl/aud_pkg.sv - shared types, widths and helpers for the audio record writer
package aud_pkg;
    localparam int ADDR_W    = 20;
    localparam int DATA_W    = 16;
    localparam int BIT_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        REC   = 2'd2,
        PAUSE = 2'd3
    } rec_state_t;

    // |sample| with the single unrepresentable magnitude clamped to full scale
    function automatic logic [DATA_W-1:0] abs_sat(input logic [DATA_W-1:0] s);
        if (!s[DATA_W-1])
            return s;
        else if (s == {1'b1, {(DATA_W-1){1'b0}}})
            return {1'b0, {(DATA_W-1){1'b1}}};
        else
            return ~s + 1'b1;
    endfunction
endpackage

// File: rtl/i2s_rx_shift.sv
// rtl/i2s_rx_shift.sv - synchronizes the I2S pins and deserializes one left-channel word per frame
module i2s_rx_shift
    import aud_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bclk,
    input  logic              lrck,
    input  logic              sdat,
    input  logic              active,
    output logic              lrck_fall,
    output logic [DATA_W-1:0] word,
    output logic              valid
);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W);

    // [0],[1] are the synchronizer; [2] is the history flop for edge detection
    logic [2:0]           bclk_s;
    logic [2:0]           lrck_s;
    logic [1:0]           dat_s;
    logic [BIT_CNT_W-1:0] cnt;
    logic [DATA_W-1:0]    sr;
    logic                 bclk_rise;

    assign bclk_rise = bclk_s[1] & ~bclk_s[2];
    assign lrck_fall = ~lrck_s[1] & lrck_s[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_s <= '0;
            lrck_s <= '0;
            dat_s  <= '0;
            cnt    <= '0;
            sr     <= '0;
            word   <= '0;
            valid  <= 1'b0;
        end else begin
            bclk_s <= {bclk_s[1:0], bclk};
            lrck_s <= {lrck_s[1:0], lrck};
            dat_s  <= {dat_s[0], sdat};
            valid  <= 1'b0;
            if (!active || lrck_fall) begin
                cnt <= '0;
                sr  <= '0;
            end else if (bclk_rise && !lrck_s[1] && cnt <= LAST_BIT) begin
                // edge 0 is the I2S one-bit delay; edges 1..16 carry MSB..LSB
                cnt <= cnt + 1'b1;
                if (cnt != '0)
                    sr <= {sr[DATA_W-2:0], dat_s[1]};
                if (cnt == LAST_BIT) begin
                    word  <= {sr[DATA_W-2:0], dat_s[1]};
                    valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/aud_rec_writer.sv
// rtl/aud_rec_writer.sv - record FSM writing left-channel samples to SRAM; optional REC_PEAK_METER_EN
module aud_rec_writer
    import aud_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_bclk,
    input  logic              i_adclrck,
    input  logic              i_adcdat,
    input  logic [ADDR_W-1:0] i_stop_addr,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_data,
    output logic              o_sram_we,
    output logic [1:0]        o_state,
    output logic              o_fin
`ifdef REC_PEAK_METER_EN
    ,
    output logic [DATA_W-1:0] o_peak
`endif
);
    rec_state_t        state;
    logic              rec_active;
    logic              lrck_fall;
    logic              word_valid;
    logic [DATA_W-1:0] rx_word;
    logic              last_write;
    logic              go_align;

    assign rec_active = (state == REC);
    assign o_state    = state;
    assign last_write = o_sram_we && (o_sram_addr == i_stop_addr);
    assign go_align   = i_start && !i_stop && !i_pause && (state == IDLE || state == PAUSE);

    i2s_rx_shift u_rx (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .bclk      (i_bclk),
        .lrck      (i_adclrck),
        .sdat      (i_adcdat),
        .active    (rec_active),
        .lrck_fall (lrck_fall),
        .word      (rx_word),
        .valid     (word_valid)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_sram_addr <= '0;
            o_sram_data <= '0;
            o_sram_we   <= 1'b0;
            o_fin       <= 1'b0;
        end else begin
            o_sram_we <= 1'b0;
            // post-write bookkeeping happens even if a pause/stop lands on this cycle
            if (o_sram_we && !last_write)
                o_sram_addr <= o_sram_addr + 1'b1;
            case (state)
                IDLE: begin
                    if (go_align) begin
                        state       <= ALIGN;
                        o_sram_addr <= '0;
                        o_fin       <= 1'b0;
                    end
                end
                ALIGN: begin
                    if (i_stop) begin
                        state <= IDLE;
                        o_fin <= 1'b1;
                    end else if (i_pause)
                        state <= PAUSE;
                    else if (lrck_fall)
                        state <= REC;
                end
                REC: begin
                    if (i_stop || last_write) begin
                        state <= IDLE;
                        o_fin <= 1'b1;
                    end else if (i_pause)
                        state <= PAUSE;
                    else if (word_valid) begin
                        o_sram_data <= rx_word;
                        o_sram_we   <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (i_stop) begin
                        state <= IDLE;
                        o_fin <= 1'b1;
                    end else if (go_align)
                        state <= ALIGN;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef REC_PEAK_METER_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_peak <= '0;
        else if (go_align)
            o_peak <= '0;
        else if (o_sram_we && abs_sat(o_sram_data) > o_peak)
            o_peak <= abs_sat(o_sram_data);
    end
`endif
endmodule
